// File: rtl/mem_stage_wb_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_wb_reg_if
//  Description : M-stage inputs and W-stage outputs of the memory stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_wb_reg_if #(
   parameter int DATA_SIZE = 32
);
   logic [DATA_SIZE-1:0] ALUOutM;
   logic [DATA_SIZE-1:0] WriteDataM;
   logic [4:0]           WriteRegM;
   logic                 RegWriteM;
   logic                 MemtoRegM;
   logic                 MemWriteM;

   logic [DATA_SIZE-1:0] ReadDataW;
   logic [DATA_SIZE-1:0] ALUOutW;
   logic [4:0]           WriteRegW;
   logic                 RegWriteW;
   logic                 MemtoRegW;
   logic                 AlignErrW;
   logic [DATA_SIZE-1:0] ResultW;

   // Upstream pipeline side: drives M-stage controls, observes W stage.
   modport master (
      output ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM,
      input  ReadDataW, ALUOutW, WriteRegW, RegWriteW, MemtoRegW, AlignErrW, ResultW
   );

   modport slave (
      input  ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM,
      output ReadDataW, ALUOutW, WriteRegW, RegWriteW, MemtoRegW, AlignErrW, ResultW
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_wb_reg
//  Description : MIPS memory stage (word-addressed data memory) plus the
//                Mem/Writeback pipeline register and result mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_wb_reg #(
   parameter int DATA_SIZE = 32,
   parameter int MEM_DEPTH = 64,
   parameter int ADDR_BITS = 6
) (
   input  logic               clk,
   input  logic               reset,
   mem_stage_wb_reg_if.slave  bus
);

   localparam logic [1:0] c_ALIGNED = 2'b00;

   logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];

   logic [ADDR_BITS-1:0] w_index;
   logic                 w_mem_access;
   logic                 w_misalign;
   logic                 w_store_en;
   logic [DATA_SIZE-1:0] w_rd;

   logic [DATA_SIZE-1:0] readdata_d,  readdata_q;
   logic [DATA_SIZE-1:0] aluout_d,    aluout_q;
   logic [4:0]           writereg_d,  writereg_q;
   logic                 regwrite_d,  regwrite_q;
   logic                 memtoreg_d,  memtoreg_q;
   logic                 alignerr_d,  alignerr_q;

   // Address bits above the word index are intentionally ignored (wrap).
   logic w_unused_addr;
   assign w_unused_addr = ^bus.ALUOutM[DATA_SIZE-1:ADDR_BITS+2];

   assign w_index      = bus.ALUOutM[ADDR_BITS+1:2];
   assign w_mem_access = bus.MemWriteM | bus.MemtoRegM;
   assign w_misalign   = (bus.ALUOutM[1:0] != c_ALIGNED) & w_mem_access;
   assign w_store_en   = bus.MemWriteM & ~w_misalign;

   // Read returns the pre-write word, so an illegal load+store sees old data.
   always_comb begin
      w_rd = '0;
      if (bus.MemtoRegM && !w_misalign) begin
         w_rd = mem_q[w_index];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (w_store_en) begin
         mem_q[w_index] <= bus.WriteDataM;
      end
   end

   always_comb begin
      readdata_d = w_rd;
      aluout_d   = bus.ALUOutM;
      writereg_d = bus.WriteRegM;
      memtoreg_d = bus.MemtoRegM;
      alignerr_d = w_misalign;
      // A faulting load must never reach the register file.
      regwrite_d = bus.RegWriteM & ~(bus.MemtoRegM & w_misalign);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readdata_q <= '0;
         aluout_q   <= '0;
         writereg_q <= '0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         alignerr_q <= 1'b0;
      end else begin
         readdata_q <= readdata_d;
         aluout_q   <= aluout_d;
         writereg_q <= writereg_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         alignerr_q <= alignerr_d;
      end
   end

   assign bus.ReadDataW = readdata_q;
   assign bus.ALUOutW   = aluout_q;
   assign bus.WriteRegW = writereg_q;
   assign bus.RegWriteW = regwrite_q;
   assign bus.MemtoRegW = memtoreg_q;
   assign bus.AlignErrW = alignerr_q;
   assign bus.ResultW   = memtoreg_q ? readdata_q : aluout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_wb_reg
//  Description : Scoreboard bench for mem_stage_wb_reg against a word-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_wb_reg;

   logic clk;
   logic reset;

   mem_stage_wb_reg_if #(.DATA_SIZE(32)) bus ();

   mem_stage_wb_reg #(
      .DATA_SIZE (32),
      .MEM_DEPTH (64),
      .ADDR_BITS (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  wr;
      logic        rw;
      logic        m2r;
      logic        ae;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] model_mem [64];
   int          tests;
   int          fails;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Model: byte address wraps modulo 256, word = address / 4.
   task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                        input logic rw, input logic m2r, input logic mw);
      exp_t e;
      int   idx;
      bit   mis;
      @(negedge clk);
      bus.ALUOutM    = alu;
      bus.WriteDataM = wd;
      bus.WriteRegM  = wr;
      bus.RegWriteM  = rw;
      bus.MemtoRegM  = m2r;
      bus.MemWriteM  = mw;
      idx   = int'((alu % 256) / 4);
      mis   = ((alu % 4) != 0) && (mw || m2r);
      e.rd  = (m2r && !mis) ? model_mem[idx] : 32'h0;
      e.alu = alu;
      e.wr  = wr;
      e.m2r = m2r;
      e.ae  = mis;
      e.rw  = rw && !(m2r && mis);
      if (mw && !mis) model_mem[idx] = wd;
      exp_q.push_back(e);
   endtask

   task automatic drive_nop();
      bus.ALUOutM    = '0;
      bus.WriteDataM = '0;
      bus.WriteRegM  = '0;
      bus.RegWriteM  = 1'b0;
      bus.MemtoRegM  = 1'b0;
      bus.MemWriteM  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      drive_nop();
      reset = 1'b0;
      #1;
      chk("rst_ReadDataW", bus.ReadDataW, 32'h0);
      chk("rst_ALUOutW",   bus.ALUOutW,   32'h0);
      chk("rst_WriteRegW", {27'h0, bus.WriteRegW}, 32'h0);
      chk("rst_RegWriteW", {31'h0, bus.RegWriteW}, 32'h0);
      chk("rst_MemtoRegW", {31'h0, bus.MemtoRegW}, 32'h0);
      chk("rst_AlignErrW", {31'h0, bus.AlignErrW}, 32'h0);
      chk("rst_ResultW",   bus.ResultW,   32'h0);
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Monitor: W outputs are valid one cycle after each issued M-stage op.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ReadDataW", bus.ReadDataW, e.rd);
            chk("ALUOutW",   bus.ALUOutW,   e.alu);
            chk("WriteRegW", {27'h0, bus.WriteRegW}, {27'h0, e.wr});
            chk("RegWriteW", {31'h0, bus.RegWriteW}, {31'h0, e.rw});
            chk("MemtoRegW", {31'h0, bus.MemtoRegW}, {31'h0, e.m2r});
            chk("AlignErrW", {31'h0, bus.AlignErrW}, {31'h0, e.ae});
            chk("ResultW",   bus.ResultW,   e.m2r ? e.rd : e.alu);
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int          op;
      tests = 0;
      fails = 0;
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
      drive_nop();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Store then load, ALU passthrough
      issue(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
      issue(32'h10, 32'h0,        5'd5, 1'b1, 1'b1, 1'b0);
      issue(32'h12345678, 32'h0,  5'd9, 1'b1, 1'b0, 1'b0);
      // Wrap-around
      issue(32'h104, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1);
      issue(32'h004, 32'h0,        5'd7, 1'b1, 1'b1, 1'b0);
      // Misaligned store and load
      issue(32'h22, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1);
      issue(32'h20, 32'h0,        5'd3, 1'b1, 1'b1, 1'b0);
      issue(32'h23, 32'h0,        5'd4, 1'b1, 1'b1, 1'b0);
      // Illegal load+store: write happens, old word is captured
      issue(32'h10, 32'hCAFEF00D, 5'd6, 1'b1, 1'b1, 1'b1);
      issue(32'h10, 32'h0,        5'd6, 1'b1, 1'b1, 1'b0);
      // Back-to-back alternating stores and loads
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) issue(32'h40 + 32'(i * 4), 32'h1000 + 32'(i), 5'd0, 1'b0, 1'b0, 1'b1);
         else            issue(32'h40 + 32'((i - 1) * 4), 32'h0, 5'(i), 1'b1, 1'b1, 1'b0);
      end

      do_reset();
      issue(32'h0,  32'h0, 5'd1, 1'b1, 1'b1, 1'b0);
      issue(32'h4,  32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
      issue(32'hFC, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
      issue(32'h10, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);

      for (int n = 0; n < 400; n++) begin
         a  = ($urandom() & 32'hFFFFFF00) | 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         d  = $urandom();
         op = $urandom_range(0, 9);
         case (op)
            0, 1, 2: issue(a, d, 5'($urandom), 1'b0, 1'b0, 1'b1);
            3, 4, 5: issue(a, d, 5'($urandom), 1'b1, 1'b1, 1'b0);
            6, 7:    issue(a, d, 5'($urandom), 1'($urandom), 1'b0, 1'b0);
            8:       issue(a, d, 5'($urandom), 1'($urandom), 1'b1, 1'b1);
            default: issue(a, d, 5'($urandom), 1'($urandom), 1'b0, 1'b0);
         endcase
         if (n == 200) do_reset();
      end

      @(negedge clk);
      drive_nop();
      @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage_wb_reg.md
Name: mem_stage_wb_reg

Overview:
- Memory stage of the 5-stage MIPS pipeline, including the Mem/Writeback pipeline register.
- Consumes the Exe/Mem register outputs and holds the word-addressed data memory, with synchronous write and combinational read.
- Registers load data, ALU result, destination register and control into the W stage.
- Drives ResultW to the register file and the forwarding/hazard logic.

Parameters:
- data_size, 32, datapath and memory word width in bits.
- mem_depth, 64, number of data-memory words; must be a power of two.
- addr_bits, 6, log2(mem_depth); word-index width.

Ports:
- clk  input  1  pipeline clock; rising edge active.
- reset  input  1  asynchronous, active-low reset.
- ALUOutM  input  data_size  byte address for loads/stores; result for ALU ops.
- WriteDataM  input  data_size  store data.
- WriteRegM  input  5  destination register number.
- RegWriteM  input  1  instruction writes the register file.
- MemtoRegM  input  1  instruction is a load.
- MemWriteM  input  1  instruction is a store.
- ReadDataW  output  data_size  registered load data.
- ALUOutW  output  data_size  registered ALU result.
- WriteRegW  output  5  registered destination register.
- RegWriteW  output  1  registered register-file write enable.
- MemtoRegW  output  1  registered load select.
- AlignErrW  output  1  registered misaligned-access flag.
- ResultW  output  data_size  MemtoRegW ? ReadDataW : ALUOutW; combinational from W registers only.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - ReadDataW, ALUOutW, WriteRegW, RegWriteW, MemtoRegW and AlignErrW go to 0, so ResultW=0.
  - Every data-memory word is cleared to 0.
  - Reset mid-operation discards any store in flight; no partial write occurs.
- Addressing:
  - Word index = ALUOutM[addr_bits+1:2].
  - Upper address bits are ignored, so addresses wrap modulo mem_depth*4 bytes.
  - Example: 0x100 with depth 64 maps to word 0.
- Misalignment:
  - misalignM = ALUOutM[1:0]!=0 AND (MemWriteM OR MemtoRegM).
  - ALU-only instructions never flag misalignment.
- Store:
  - On the rising edge, when MemWriteM=1 and misalignM=0, mem[index] <= WriteDataM.
  - A misaligned store is suppressed and memory is unchanged.
- Load read:
  - Combinational: rdM = mem[index], or 0 when misalignM=1 or MemtoRegM=0.
- Mem/WB register: on every rising edge (no stall or flush input), all outputs update together:
  - ReadDataW <= rdM
  - ALUOutW <= ALUOutM
  - WriteRegW <= WriteRegM
  - MemtoRegW <= MemtoRegM
  - AlignErrW <= misalignM
  - RegWriteW <= RegWriteM AND NOT (MemtoRegM AND misalignM). A faulting load must not write the register file.
- Latency: one cycle from M inputs to W outputs.
- Store followed by load:
  - A store at edge N followed by a load of the same word in the next cycle reads the new data.
  - ReadDataW holds that data after edge N+1.
- Simultaneous MemWriteM=1 and MemtoRegM=1 is not legal decoder output. The block still performs the write, and ReadDataW captures the pre-write (old) word.
- Writes to WriteRegM=0 are passed through unchanged; $zero is protected by the register file.
- No X propagation: the memory is always initialised by reset, so reads before any store return 0.

Test Plan:
- Reset check: assert reset=0 mid-run after several stores -> all W outputs and ResultW are 0 immediately; loads of addresses 0x0, 0x4 and 0xFC then return 0.
- Store then load: store 0xDEADBEEF to 0x10, then load 0x10 with WriteRegM=5 in the next cycle -> after the following edge, ReadDataW=0xDEADBEEF, ResultW=0xDEADBEEF, WriteRegW=5, RegWriteW=1.
- ALU passthrough: ALUOutM=0x12345678, RegWriteM=1, MemtoRegM=0, WriteRegM=9 -> next cycle ALUOutW=0x12345678, ResultW=0x12345678, AlignErrW=0 (low bits ignored because there is no memory access).
- Wrap-around: store 0xA5A5A5A5 to 0x104, then load 0x004 -> ReadDataW=0xA5A5A5A5 (depth 64).
- Misaligned accesses:
  - Store 0x11111111 to 0x22 -> AlignErrW=1, and a later load of 0x20 returns its prior value (0).
  - Load 0x23 with RegWriteM=1 -> AlignErrW=1, ReadDataW=0, RegWriteW=0.
- Back-to-back stream: 8 consecutive alternating stores and loads to distinct words -> each W output matches its M-stage input exactly one cycle later with no bubbles, and the load data equals the previously stored values.
